// File: rtl/buf_pkg.sv
// Shared definitions for the buffer block allocator.
// Holds the default geometry, the index-width derivation used by every file of the
// allocator, and the common index/count types for the default configuration.
package buf_pkg;

  localparam int unsigned NUM_BLOCKS_DEF = 16;
  localparam int unsigned NUM_PORTS_DEF  = 4;

  // Index width for a set of n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W_DEF  = idx_w(NUM_BLOCKS_DEF);
  localparam int unsigned PORT_W_DEF = idx_w(NUM_PORTS_DEF);

  typedef logic [IDX_W_DEF-1:0]  blk_idx_t;
  typedef logic [PORT_W_DEF-1:0] port_idx_t;
  typedef logic [IDX_W_DEF:0]    blk_cnt_t;

endpackage

// File: rtl/buf_alloc_ctrl_if.sv
// Allocation / release bus between the write-port controllers, the read-side
// release logic and the block allocator.
//   master : requester side  - drives alloc_req, free_valid, free_idx, flush
//   slave  : allocator side  - drives alloc_gnt, alloc_idx, free_cnt, full,
//                              err_double_free (and alloc_stall_cnt)
// Optional macro BUF_ALLOC_STATS_EN adds the 16-bit alloc_stall_cnt signal.
interface buf_alloc_ctrl_if
  import buf_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF
);

  localparam int unsigned IDX_W = idx_w(NUM_BLOCKS);

  logic [NUM_PORTS-1:0] alloc_req;
  logic [NUM_PORTS-1:0] alloc_gnt;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 free_valid;
  logic [IDX_W-1:0]     free_idx;
  logic                 flush;
  logic [IDX_W:0]       free_cnt;
  logic                 full;
  logic                 err_double_free;
`ifdef BUF_ALLOC_STATS_EN
  logic [15:0]          alloc_stall_cnt;

  modport master (
    output alloc_req, free_valid, free_idx, flush,
    input  alloc_gnt, alloc_idx, free_cnt, full, err_double_free, alloc_stall_cnt
  );

  modport slave (
    input  alloc_req, free_valid, free_idx, flush,
    output alloc_gnt, alloc_idx, free_cnt, full, err_double_free, alloc_stall_cnt
  );
`else
  modport master (
    output alloc_req, free_valid, free_idx, flush,
    input  alloc_gnt, alloc_idx, free_cnt, full, err_double_free
  );

  modport slave (
    input  alloc_req, free_valid, free_idx, flush,
    output alloc_gnt, alloc_idx, free_cnt, full, err_double_free
  );
`endif

endinterface

// File: rtl/buf_alloc_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at position ptr, wrapping at N, and returns the first hit.
//   req  : request vector
//   ptr  : search start position
//   gnt  : one-hot grant (zero when nothing requests)
//   idx  : binary index of the granted position
//   any  : at least one request present
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [$clog2(N)-1:0]  ptr,
  output logic [N-1:0]          gnt,
  output logic [$clog2(N)-1:0]  idx,
  output logic                  any
);

  localparam int unsigned W = $clog2(N);

  always_comb begin
    int unsigned pos;
    logic [W-1:0] pidx;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = 0;
    pidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      pidx = W'(pos);
      if (!any && req[pidx]) begin
        any       = 1'b1;
        gnt[pidx] = 1'b1;
        idx       = pidx;
      end
    end
  end

endmodule

// File: rtl/buf_alloc_ctrl.sv
// Free-block allocator and round-robin arbiter for the shared multi-port buffer.
// Keeps a used/free bitmap (1 = used), grants at most one lowest-index free block per
// cycle to one requesting write port, and accepts one release per cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : buf_alloc_ctrl_if.slave - alloc_req/alloc_gnt/alloc_idx,
//              free_valid/free_idx, flush, free_cnt, full, err_double_free
// Optional macro BUF_ALLOC_STATS_EN adds bus.alloc_stall_cnt, a saturating count of
// cycles in which an eligible request found the buffer full.
module buf_alloc_ctrl
  import buf_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF
) (
  input logic             clk,
  input logic             rst,
  buf_alloc_ctrl_if.slave bus
);

  localparam int unsigned IDX_W  = idx_w(NUM_BLOCKS);
  localparam int unsigned PORT_W = idx_w(NUM_PORTS);
  localparam int unsigned CNT_W  = IDX_W + 1;

  logic [NUM_BLOCKS-1:0] bitmap_q, bitmap_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  arb_gnt;
  logic [PORT_W-1:0]     arb_idx;
  logic                  arb_any;

  logic [NUM_BLOCKS-1:0] blk_onehot;
  logic [IDX_W-1:0]      blk_sel;
  logic                  blk_avail;
  logic                  do_grant;
  logic                  rel_hit;
  logic                  dbl_free;
  logic                  full;

  // A port holding its grant this cycle sits out, so steady requesters alternate.
  assign eligible = bus.alloc_req & ~gnt_q;
  assign full     = (cnt_q == '0);

  rr_arbiter #(
    .N (NUM_PORTS)
  ) u_rr_arbiter (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // First-zero finder: isolates the lowest clear bit; all-ones yields zero.
  assign blk_onehot = (bitmap_q + NUM_BLOCKS'(1)) & ~bitmap_q;
  assign blk_avail  = |blk_onehot;

  always_comb begin
    blk_sel = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (blk_onehot[i]) blk_sel = blk_sel | IDX_W'(i);
    end
  end

  assign do_grant = arb_any & blk_avail & ~bus.flush;
  // Release checks the pre-allocation bitmap; a freshly granted block is never 1 there.
  assign rel_hit  = bus.free_valid &  bitmap_q[bus.free_idx];
  assign dbl_free = bus.free_valid & ~bitmap_q[bus.free_idx];

  always_comb begin
    bitmap_d = bitmap_q;
    gnt_d    = '0;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    if (bus.flush) begin
      bitmap_d = '0;
      cnt_d    = CNT_W'(NUM_BLOCKS);
      err_d    = 1'b0;
      rr_ptr_d = '0;
    end else begin
      if (do_grant) begin
        bitmap_d = bitmap_d | blk_onehot;
        gnt_d    = arb_gnt;
        idx_d    = blk_sel;
        rr_ptr_d = (arb_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : PORT_W'(arb_idx + PORT_W'(1));
      end
      if (rel_hit) bitmap_d[bus.free_idx] = 1'b0;
      if (dbl_free) err_d = 1'b1;
      // Grant needs a free block and release needs a used one, so no wrap is possible.
      cnt_d = cnt_q - CNT_W'(do_grant) + CNT_W'(rel_hit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_q <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= CNT_W'(NUM_BLOCKS);
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.alloc_gnt       = gnt_q;
  assign bus.alloc_idx       = idx_q;
  assign bus.free_cnt        = cnt_q;
  assign bus.full            = full;
  assign bus.err_double_free = err_q;

`ifdef BUF_ALLOC_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.flush) begin
      stall_d = '0;
    end else if ((|eligible) && full && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.alloc_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_buf_alloc_ctrl.sv
// Self-checking bench for buf_alloc_ctrl: directed vectors with literal expectations,
// plus a per-cycle comparison against a behavioural model of the allocator.
module tb_buf_alloc_ctrl;
  import buf_pkg::*;

  localparam int NB = 16;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buf_alloc_ctrl_if #(.NUM_BLOCKS(NB), .NUM_PORTS(NP)) bus ();

  buf_alloc_ctrl #(
    .NUM_BLOCKS (NB),
    .NUM_PORTS  (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: a set of used blocks, the grant currently on the bus,
  // the next port to favour, and the sticky error / stall statistics.
  bit             m_used[NB];
  logic [NP-1:0]  m_gnt;
  int             m_idx;
  int             m_rr;
  bit             m_err;
  int             m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_free_cnt();
    int n = 0;
    for (int i = 0; i < NB; i++) if (!m_used[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_used[i] = 1'b0;
    m_gnt   = '0;
    m_idx   = 0;
    m_rr    = 0;
    m_err   = 1'b0;
    m_stall = 0;
  endtask

  task automatic model_step();
    logic [NP-1:0] elig;
    bit            was_used[NB];
    int            blk;
    int            port;
    bit            full_now;
    if (bus.flush) begin
      model_reset();
      return;
    end
    elig     = bus.alloc_req & ~m_gnt;
    full_now = (m_free_cnt() == 0);
    if (elig != 0 && full_now && m_stall < 65535) m_stall++;
    for (int i = 0; i < NB; i++) was_used[i] = m_used[i];
    blk = -1;
    for (int i = NB - 1; i >= 0; i--) if (!was_used[i]) blk = i;
    port = -1;
    for (int k = NP - 1; k >= 0; k--) if (elig[(m_rr + k) % NP]) port = (m_rr + k) % NP;
    m_gnt = '0;
    if (port >= 0 && blk >= 0) begin
      m_gnt[port] = 1'b1;
      m_used[blk] = 1'b1;
      m_idx       = blk;
      m_rr        = (port + 1) % NP;
    end
    if (bus.free_valid) begin
      if (was_used[int'(bus.free_idx)]) m_used[int'(bus.free_idx)] = 1'b0;
      else m_err = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("m_gnt", bus.alloc_gnt, m_gnt);
      if (m_gnt != 0) check("m_idx", bus.alloc_idx, m_idx);
      check("m_free_cnt", bus.free_cnt, m_free_cnt());
      check("m_full", bus.full, (m_free_cnt() == 0));
      check("m_err", bus.err_double_free, m_err);
`ifdef BUF_ALLOC_STATS_EN
      check("m_stall", bus.alloc_stall_cnt, m_stall);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic do_flush();
    bus.flush      = 1'b1;
    bus.alloc_req  = '0;
    bus.free_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic fill_until_full(input string name);
    bus.alloc_req = 4'b1111;
    for (int c = 0; c < 40 && !bus.full; c++) @(negedge clk);
    check(name, bus.full, 1);
  endtask

  int t2_port[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.alloc_req  = '0;
    bus.free_valid = 1'b0;
    bus.free_idx   = '0;
    bus.flush      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", bus.alloc_gnt, 0);
    check("rst_idx", bus.alloc_idx, 0);
    check("rst_cnt", bus.free_cnt, 16);
    check("rst_full", bus.full, 0);
    check("rst_err", bus.err_double_free, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // 1: single steady requester, granted every other cycle
    @(negedge clk);
    bus.alloc_req = 4'b0001;
    @(negedge clk);
    check("t1_gnt_a", bus.alloc_gnt, 4'b0001);
    check("t1_idx_a", bus.alloc_idx, 0);
    check("t1_cnt_a", bus.free_cnt, 15);
    @(negedge clk);
    check("t1_gnt_gap", bus.alloc_gnt, 0);
    check("t1_cnt_gap", bus.free_cnt, 15);
    @(negedge clk);
    check("t1_gnt_b", bus.alloc_gnt, 4'b0001);
    check("t1_idx_b", bus.alloc_idx, 1);
    check("t1_cnt_b", bus.free_cnt, 14);
    do_flush();
    check("t1_flush_cnt", bus.free_cnt, 16);

    // 2: all ports requesting, round-robin order
    bus.alloc_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t2_gnt_%0d", k), bus.alloc_gnt, 32'(1) << t2_port[k]);
      check($sformatf("t2_idx_%0d", k), bus.alloc_idx, k);
    end
    do_flush();

    // 3: fill, then a release re-opens exactly one block
    fill_until_full("t3_full");
    check("t3_last_idx", bus.alloc_idx, 15);
    @(negedge clk);
    check("t3_nogrant", bus.alloc_gnt, 0);
    check("t3_full_hold", bus.full, 1);
    check("t3_err", bus.err_double_free, 0);
    bus.free_valid = 1'b1;
    bus.free_idx   = 4'd5;
    @(negedge clk);
    bus.free_valid = 1'b0;
    check("t3_rel_gnt", bus.alloc_gnt, 0);
    check("t3_rel_full", bus.full, 0);
    check("t3_rel_cnt", bus.free_cnt, 1);
    @(negedge clk);
    check("t3_regnt_any", |bus.alloc_gnt, 1);
    check("t3_regnt_idx", bus.alloc_idx, 5);
    check("t3_regnt_full", bus.full, 1);
    @(negedge clk);
    check("t3_after_gnt", bus.alloc_gnt, 0);

    // 4: release and request while full in the same cycle
    bus.free_valid = 1'b1;
    bus.free_idx   = 4'd3;
    @(negedge clk);
    bus.free_valid = 1'b0;
    check("t4_same_gnt", bus.alloc_gnt, 0);
    check("t4_same_cnt", bus.free_cnt, 1);
    @(negedge clk);
    check("t4_next_any", |bus.alloc_gnt, 1);
    check("t4_next_idx", bus.alloc_idx, 3);
    check("t4_next_cnt", bus.free_cnt, 0);
    do_flush();

    // 5: double free, sticky error, flush clears error and pointer
    bus.alloc_req = 4'b0001;
    @(negedge clk);
    bus.alloc_req = '0;
    check("t5_gnt0", bus.alloc_gnt, 4'b0001);
    bus.free_valid = 1'b1;
    bus.free_idx   = 4'd7;
    @(negedge clk);
    bus.free_valid = 1'b0;
    check("t5_err", bus.err_double_free, 1);
    check("t5_cnt", bus.free_cnt, 15);
    @(negedge clk);
    check("t5_err_sticky", bus.err_double_free, 1);
    do_flush();
    check("t5_flush_err", bus.err_double_free, 0);
    check("t5_flush_cnt", bus.free_cnt, 16);
    bus.alloc_req = 4'b1001;
    @(negedge clk);
    bus.alloc_req = '0;
    check("t5_rr_reset", bus.alloc_gnt, 4'b0001);
    @(negedge clk);

    // 6: asynchronous reset in the middle of a grant
    bus.alloc_req = 4'b1111;
    @(negedge clk);
    check("t6_pre_any", |bus.alloc_gnt, 1);
    check("t6_pre_idx", bus.alloc_idx, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_gnt", bus.alloc_gnt, 0);
    check("t6_idx", bus.alloc_idx, 0);
    check("t6_cnt", bus.free_cnt, 16);
    check("t6_full", bus.full, 0);
    check("t6_err", bus.err_double_free, 0);
    model_reset();
    @(negedge clk);
    bus.alloc_req = '0;
    rst = 1'b0;
    @(negedge clk);

`ifdef BUF_ALLOC_STATS_EN
    fill_until_full("t6s_full");
    bus.alloc_req = '0;
    check("t6s_stall0", bus.alloc_stall_cnt, 0);
    @(negedge clk);
    bus.alloc_req = 4'b0001;
    repeat (5) @(negedge clk);
    bus.alloc_req = '0;
    check("t6s_stall5", bus.alloc_stall_cnt, 5);
    do_flush();
    check("t6s_flush", bus.alloc_stall_cnt, 0);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
